fa_serial_seq: RTL and testbench
================================

# fa_serial_seq

Bit-serial sequencer for the single-bit full-adder datapath (XOR/AND/OR sum and carry network).
- Accepts two W-bit operands over a valid/ready handshake.
- Presents one bit pair per cycle, LSB first, to an external combinational full adder, and keeps the carry in a register between cycles.
- Assembles the W-bit sum and the final carry, then returns them over a second valid/ready handshake.
- Sits between the register-level operand source and the shared full-adder cell, so one adder cell serves W-bit additions.

## Interface
Parameters:
- W, 8, operand width in bits; legal range W >= 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for bit 0.
- sub  input  1  subtract request; present only with FA_SEQ_SUB_EN.
- fa_a  output  1  A bit presented to the full adder.
- fa_b  output  1  B bit presented to the full adder.
- fa_ci  output  1  carry presented to the full adder.
- fa_s  input  1  full-adder sum, combinational from fa_a/fa_b/fa_ci.
- fa_co  input  1  full-adder carry-out, combinational.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- cout  output  1  final carry-out.

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, the block captures a into shift register SA, b into SB, and cin into carry register CR.
  - Bit counter CNT (width clog2(W)) is set to 0, and the FSM goes to RUN.
- RUN:
  - fa_a=SA[0], fa_b=SB[0], fa_ci=CR.
  - Each cycle:
    - SA and SB shift right by one.
    - fa_s shifts into SUMR at the MSB; SUMR shifts right, so after W cycles bit 0 is in SUMR[0].
    - CR<=fa_co and CNT<=CNT+1.
  - When CNT==W-1, the FSM goes to DONE after this cycle's update.
- DONE:
  - out_valid=1, sum=SUMR, cout=CR.
  - When out_ready=1, the FSM goes to IDLE.
  - sum and cout stay stable while out_valid=1 and out_ready=0.
- In IDLE and DONE, fa_a=fa_b=fa_ci=0, so the shared adder sees no toggling.
- in_ready=1 only in IDLE. Operands presented while busy are not accepted and are not lost; in_valid is held by the source.
- sum and cout keep the last result after leaving DONE.
- The final carry is CR after the bit W-1 update, so there is no overflow truncation: the full result is {cout,sum}.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, fa_a=fa_b=fa_ci=0; CNT=0; SA, SB and SUMR are 0.
- Accept at edge T. Bit i is on fa_* during cycle T+1+i. out_valid rises after edge T+W, so latency from accept to out_valid is W cycles.
- Throughput: one operation per W+2 cycles when out_ready=1 at out_valid, since DONE and IDLE each take one cycle.
- Simultaneous in_valid and out_ready in DONE: out_ready is honoured and in_valid is ignored until IDLE.
- rst_n=0 in any state, including mid-RUN: on the next edge the FSM returns to IDLE with all reset values, and the partial result is discarded. No output is produced for the aborted operation.
- The fa_s/fa_co combinational path must settle within one clk period after fa_* change.

## Configuration
- FA_SEQ_SUB_EN defined:
  - Port sub exists and is captured with the operands in IDLE.
  - sub=1 loads SB with ~b and CR with 1, ignoring cin, so the block computes a-b.
  - cout=1 means no borrow.
- FA_SEQ_SUB_EN undefined: port sub is absent, and the block only adds with the given cin.

## Test plan
- W=8, a=0x5A, b=0x33, cin=0, out_ready=1 -> out_valid 8 cycles after accept, sum=0x8D, cout=0; fa_a sequence during RUN is 0,1,0,1,1,0,1,0.
- W=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum and cout hold and in_ready=0 throughout. The next in_valid is accepted only in the cycle after out_ready=1.
- rst_n=0 at RUN cycle 3 -> next cycle in_ready=1, out_valid=0, fa_* at 0. A subsequent add of 0x01+0x01 gives sum=0x02 with no residue from the aborted operation.
- With FA_SEQ_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1. Then a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/fa_serial_seq.sv
// Bit-serial add/subtract sequencer driving one external full-adder cell, LSB first.
// Optional subtract support is built in when the FA_SEQ_SUB_EN macro is defined.
module fa_serial_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef FA_SEQ_SUB_EN
    input  logic         sub,
`endif
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_ci,
    input  logic         fa_s,
    input  logic         fa_co,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_sa;
    logic [W-1:0]  r_sb;
    logic [W-1:0]  r_sumr;
    logic [W-1:0]  r_sum;
    logic          r_cr;
    logic          r_cout;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_run;

    logic [W-1:0]  w_sb_load;
    logic          w_cr_load;
    logic [W-1:0]  w_sa_shift;
    logic [W-1:0]  w_sb_shift;
    logic [W-1:0]  w_sumr_shift;

`ifdef FA_SEQ_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry to 1.
    assign w_sb_load = sub ? ~b : b;
    assign w_cr_load = sub ? 1'b1 : cin;
`else
    assign w_sb_load = b;
    assign w_cr_load = cin;
`endif

    // Operands drain toward bit 0; the adder sum enters the result at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_shift
            assign w_sa_shift[gi]   = r_sa[gi+1];
            assign w_sb_shift[gi]   = r_sb[gi+1];
            assign w_sumr_shift[gi] = r_sumr[gi+1];
        end
    endgenerate

    assign w_sa_shift[W-1]   = 1'b0;
    assign w_sb_shift[W-1]   = 1'b0;
    assign w_sumr_shift[W-1] = fa_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_sumr      <= '0;
            r_sum       <= '0;
            r_cr        <= 1'b0;
            r_cout      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sa       <= a;
                        r_sb       <= w_sb_load;
                        r_cr       <= w_cr_load;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_run      <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sa   <= w_sa_shift;
                    r_sb   <= w_sb_shift;
                    r_sumr <= w_sumr_shift;
                    r_cr   <= fa_co;
                    r_cnt  <= r_cnt + 1'b1;
                    // Result is copied out on the last bit so it survives the next operation.
                    if (r_cnt == LAST_BIT) begin
                        r_sum       <= w_sumr_shift;
                        r_cout      <= fa_co;
                        r_run       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_run       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // The shared adder sees constant zeros outside RUN.
    assign fa_a      = r_run & r_sa[0];
    assign fa_b      = r_run & r_sb[0];
    assign fa_ci     = r_run & r_cr;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_fa_serial_seq.sv
// Directed bench for fa_serial_seq: a behavioural full adder closes the loop on fa_*.
// Subtract vectors run only when FA_SEQ_SUB_EN is defined.
module tb_fa_serial_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         fa_a;
    logic         fa_b;
    logic         fa_ci;
    logic         fa_s;
    logic         fa_co;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_pass   = 0;

    fa_serial_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef FA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_ci     (fa_ci),
        .fa_s      (fa_s),
        .fa_co     (fa_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %-22s got 0x%0h exp 0x%0h ok", tag, act, exp);
        end else begin
            $display("FAIL %-22s got 0x%0h exp 0x%0h", tag, act, exp);
        end
    endtask

    // Accept one operation and follow it to DONE; leaves the bench at the first DONE negedge.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub,
                          input logic [W-1:0] esum, input logic ecout,
                          output logic [W-1:0] ci_seq);
        logic [W-1:0] a_seq;
        logic [W-1:0] b_seq;
        logic         early;
        int           k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        early    = 1'b0;
        for (int i = 0; i < W; i++) begin
            a_seq[i]  = fa_a;
            b_seq[i]  = fa_b;
            ci_seq[i] = fa_ci;
            if (out_valid || in_ready) early = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_busy_flags"}, early, 0);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_cout"}, cout, ecout);
        chk({tag, "_fa_a_seq"}, a_seq, ta);
        chk({tag, "_fa_b_seq"}, b_seq, tsub ? ~tb_v : tb_v);
        if (out_ready) begin
            @(negedge clk);
            chk({tag, "_idle_flags"}, {out_valid, in_ready}, 2'b01);
            chk({tag, "_sum_held"}, {cout, sum}, {ecout, esum});
        end
    endtask

    logic [W-1:0] ci_seq;
    logic         held_ok;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_flags", {in_ready, out_valid}, 2'b10);
        chk("rst_result", {cout, sum}, 0);
        chk("rst_fa", {fa_a, fa_b, fa_ci}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x5A + 0x33: carry chain LSB first is 0,0,1,0,0,1,1,1 -> 0xE4
        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, ci_seq);
        chk("add_5a_33_ci_seq", ci_seq, 8'hE4);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, ci_seq);
        run_op("add_00_00_c1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, ci_seq);

        // Backpressure: result held, next operands pending but not accepted.
        out_ready = 1'b0;
        run_op("bp_a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, ci_seq);
        a        = 8'h0F;
        b        = 8'h01;
        cin      = 1'b0;
        in_valid = 1'b1;
        held_ok  = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            if (!out_valid || in_ready || sum !== 8'h00 || cout !== 1'b1) held_ok = 1'b0;
        end
        chk("bp_hold", held_ok, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_flags", {in_ready, out_valid}, 2'b10);
        chk("bp_release_fa", {fa_a, fa_b, fa_ci}, 0);
        @(negedge clk);
        chk("bp_next_accepted", in_ready, 0);
        in_valid = 1'b0;
        repeat (W) @(negedge clk);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", {cout, sum}, {1'b0, 8'h10});
        @(negedge clk);

        // Reset in the middle of RUN discards the operation.
        a        = 8'hFF;
        b        = 8'hFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_flags", {in_ready, out_valid}, 2'b10);
        chk("midrst_fa", {fa_a, fa_b, fa_ci}, 0);
        chk("midrst_result", {cout, sum}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_output", out_valid, 0);
        run_op("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, ci_seq);

`ifdef FA_SEQ_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, ci_seq);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, ci_seq);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
